// File: rtl/clearable_ram_pkg.sv
// Shared definitions for the clearable RAM: controller state encoding and
// the supported read-latency range.
package clearable_ram_pkg;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 4;

  // Keeps an out-of-range latency parameter from building a degenerate pipeline.
  function automatic int clamp_latency(int lat);
    if (lat < READ_LATENCY_MIN) return READ_LATENCY_MIN;
    if (lat > READ_LATENCY_MAX) return READ_LATENCY_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/clearable_ram_if.sv
// Request/response bus of the clearable RAM; master issues requests and
// clear pulses, slave is the RAM.
interface clearable_ram_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);

  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [DATA_WIDTH/8-1:0] req_be;
  logic                    clear;
  logic                    rsp_valid;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic                    busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, clear,
    input  req_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, clear,
    output req_ready, rsp_valid, rsp_rdata, busy
  );

endinterface

// File: rtl/ram_array.sv
// Single-clock word RAM: one byte-enabled synchronous write port and one
// synchronous read port whose output register holds between reads.
module ram_array #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wbe,
  input  logic                    re,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset so it maps onto block RAM; the
  // controller's zero sweep is what initialises it.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/clearable_ram.sv
// Byte-enabled RAM with a zero-sweep clear controller and a configurable
// read-latency pipeline in front of the response port.
module clearable_ram
  import clearable_ram_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  clearable_ram_if.slave   bus
);

  localparam int LAT = clamp_latency(READ_LATENCY);
  localparam int NB  = DATA_WIDTH / 8;

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] sweep_cnt;
  logic                  clearing;
  logic                  accept;
  logic                  rd_accept;

  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [NB-1:0]         ram_wbe;
  logic [DATA_WIDTH-1:0] ram_rdata;

  logic [LAT-1:0]        valid_q;

  assign clearing      = (state == ST_CLEAR);
  assign bus.busy      = clearing;
  assign bus.req_ready = (state == ST_RUN) && !reset;
  assign accept        = bus.req_valid && bus.req_ready;
  assign rd_accept     = accept && !bus.req_write;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_CLEAR;
      sweep_cnt <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          sweep_cnt <= sweep_cnt + 1'b1;
          if (&sweep_cnt) state <= ST_RUN;
        end
        ST_RUN: begin
          // Clear pulses during a sweep never reach here, so a sweep cannot restart.
          if (bus.clear) begin
            state     <= ST_CLEAR;
            sweep_cnt <= '0;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    ram_we    = accept && bus.req_write;
    ram_waddr = bus.req_addr;
    ram_wdata = bus.req_wdata;
    ram_wbe   = bus.req_be;
    if (clearing) begin
      ram_we    = 1'b1;
      ram_waddr = sweep_cnt;
      ram_wdata = '0;
      ram_wbe   = '1;
    end
  end

  ram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram_array (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .wbe   (ram_wbe),
    .re    (rd_accept),
    .raddr (bus.req_addr),
    .rdata (ram_rdata)
  );

  // Stage 0 tracks the array's own read register; later stages add latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= rd_accept;
      for (int i = 1; i < LAT; i++) valid_q[i] <= valid_q[i-1];
    end
  end

  assign bus.rsp_valid = valid_q[LAT-1];

  if (LAT == 1) begin : g_direct
    assign bus.rsp_rdata = ram_rdata;
  end else begin : g_pipe
    logic [DATA_WIDTH-1:0] data_q [1:LAT-1];

    // Data stages load only behind a valid so the output holds between responses.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 1; i < LAT; i++) data_q[i] <= '0;
      end else begin
        if (valid_q[0]) data_q[1] <= ram_rdata;
        for (int i = 2; i < LAT; i++) begin
          if (valid_q[i-1]) data_q[i] <= data_q[i-1];
        end
      end
    end

    assign bus.rsp_rdata = data_q[LAT-1];
  end

endmodule

// File: tb/tb_clearable_ram.sv
// Scoreboard bench: one directed stimulus stream drives three RAMs with read
// latencies 1, 3 and 4; per-instance monitors compare responses to queued expectations.
module tb_clearable_ram;

  typedef struct {
    int          due;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [1:0]  req_be = '0;
  logic        clear = 1'b0;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  exp_t sb [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  clearable_ram_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) if1 ();
  clearable_ram_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) if3 ();
  clearable_ram_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) if4 ();

  assign if1.req_valid = req_valid;  assign if3.req_valid = req_valid;  assign if4.req_valid = req_valid;
  assign if1.req_write = req_write;  assign if3.req_write = req_write;  assign if4.req_write = req_write;
  assign if1.req_addr  = req_addr;   assign if3.req_addr  = req_addr;   assign if4.req_addr  = req_addr;
  assign if1.req_wdata = req_wdata;  assign if3.req_wdata = req_wdata;  assign if4.req_wdata = req_wdata;
  assign if1.req_be    = req_be;     assign if3.req_be    = req_be;     assign if4.req_be    = req_be;
  assign if1.clear     = clear;      assign if3.clear     = clear;      assign if4.clear     = clear;

  clearable_ram #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .READ_LATENCY(1)) u_l1 (.clk(clk), .reset(reset), .bus(if1));
  clearable_ram #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .READ_LATENCY(3)) u_l3 (.clk(clk), .reset(reset), .bus(if3));
  clearable_ram #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .READ_LATENCY(4)) u_l4 (.clk(clk), .reset(reset), .bus(if4));

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon_step(int k, string tag, logic v, logic [15:0] d);
    exp_t e;
    if (v === 1'b1) begin
      if (sb[k].size() == 0) begin
        check({tag, " unexpected rsp_valid"}, 32'(v), 32'd0);
      end else begin
        e = sb[k].pop_front();
        check({tag, " rsp cycle"}, cyc, e.due);
        check({tag, " rsp_rdata"}, 32'(d), 32'(e.data));
      end
    end else if (sb[k].size() > 0 && sb[k][0].due < cyc) begin
      e = sb[k].pop_front();
      check({tag, " missing rsp_valid"}, 32'(v), 32'd1);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_step(0, "L1", if1.rsp_valid, if1.rsp_rdata);
      mon_step(1, "L3", if3.rsp_valid, if3.rsp_rdata);
      mon_step(2, "L4", if4.rsp_valid, if4.rsp_rdata);
    end
  end

  // Reset at edge cyc+1 empties every pipeline stage: drop responses due at or after it.
  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 3; k++) begin
        for (int i = sb[k].size() - 1; i >= 0; i--) begin
          if (sb[k][i].due >= cyc + 1) sb[k].delete(i);
        end
      end
    end
  end

  task automatic wr(logic [7:0] a, logic [15:0] d, logic [1:0] be);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d; req_be = be;
    @(negedge clk);
  endtask

  task automatic rd(logic [7:0] a, logic [15:0] exp);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_wdata = 16'hDEAD; req_be = 2'b00;
    sb[0].push_back('{due: cyc + 1, data: exp});
    sb[1].push_back('{due: cyc + 3, data: exp});
    sb[2].push_back('{due: cyc + 4, data: exp});
    @(negedge clk);
  endtask

  task automatic idle(int n);
    req_valid = 1'b0; req_write = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(string name);
    check({name, " L1 busy"},      32'(if1.busy),      32'd1);
    check({name, " L1 req_ready"}, 32'(if1.req_ready), 32'd0);
    check({name, " L1 rsp_valid"}, 32'(if1.rsp_valid), 32'd0);
    check({name, " L1 rsp_rdata"}, 32'(if1.rsp_rdata), 32'd0);
    check({name, " L3 rsp_rdata"}, 32'(if3.rsp_rdata), 32'd0);
    check({name, " L4 rsp_valid"}, 32'(if4.rsp_valid), 32'd0);
  endtask

  // Counts negedges with busy high; a clear pulse is fired mid-sweep when pulse_at > 0.
  task automatic wait_sweep(string name, int pulse_at);
    int n = 0;
    while (if1.busy === 1'b1 && n < 1000) begin
      n++;
      check({name, " req_ready during sweep"}, 32'(if1.req_ready), 32'd0);
      clear = (n == pulse_at);
      @(negedge clk);
    end
    clear = 1'b0;
    check({name, " busy cycles"}, n, 256);
    check({name, " L1 ready after"}, 32'(if1.req_ready), 32'd1);
    check({name, " L3 busy after"},  32'(if3.busy),      32'd0);
    check({name, " L4 ready after"}, 32'(if4.req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    check_reset_outputs("reset");
    reset = 1'b0;
    wait_sweep("initial sweep", 0);

    rd(8'h7F, 16'h0000);

    wr(8'h10, 16'hABCD, 2'b11);
    wr(8'h10, 16'h1234, 2'b01);
    rd(8'h10, 16'hAB34);
    wr(8'h10, 16'hFFFF, 2'b00);
    rd(8'h10, 16'hAB34);
    wr(8'h10, 16'h5600, 2'b10);
    rd(8'h10, 16'h5634);
    wr(8'hFF, 16'hBEEF, 2'b11);
    rd(8'hFF, 16'hBEEF);
    rd(8'h00, 16'h0000);

    wr(8'h01, 16'h1111, 2'b11);
    wr(8'h02, 16'h2222, 2'b11);
    wr(8'h03, 16'h3333, 2'b11);
    rd(8'h01, 16'h1111);
    rd(8'h02, 16'h2222);
    rd(8'h03, 16'h3333);
    idle(8);
    check("L1 rdata hold", 32'(if1.rsp_rdata), 32'h3333);
    check("L3 rdata hold", 32'(if3.rsp_rdata), 32'h3333);
    check("L4 rdata hold", 32'(if4.rsp_rdata), 32'h3333);
    check("L4 valid idle", 32'(if4.rsp_valid), 32'd0);

    wr(8'h05, 16'h5555, 2'b11);
    clear = 1'b1;
    rd(8'h05, 16'h5555);
    clear = 1'b0;
    req_valid = 1'b0;
    check("clear L1 req_ready next", 32'(if1.req_ready), 32'd0);
    check("clear L4 busy next",      32'(if4.busy),      32'd1);
    wait_sweep("clear sweep", 100);
    rd(8'h05, 16'h0000);
    rd(8'h10, 16'h0000);
    idle(2);

    wr(8'h20, 16'h7777, 2'b11);
    rd(8'h20, 16'h7777);
    idle(1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid-read reset");
    reset = 1'b0;
    wait_sweep("post-reset sweep", 0);
    rd(8'h20, 16'h0000);
    idle(8);

    check("L1 scoreboard drained", sb[0].size(), 0);
    check("L3 scoreboard drained", sb[1].size(), 0);
    check("L4 scoreboard drained", sb[2].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
